// File: rtl/stream_fifo.sv
// stream_fifo: single-clock valid/ready FIFO with occupancy count and status flags.
// FWFT=1 presents the oldest word combinationally; FWFT=0 returns a popped word
// one cycle after the read request.
// Optional high-water mark: define STREAM_FIFO_PEAK_EN to build the peak occupancy
// register; otherwise peak_occ_out is tied to zero.
module stream_fifo #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 1
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       flush_in,
    input  logic                       s_valid_in,
    input  logic [WIDTH-1:0]           s_data_in,
    output logic                       s_ready_out,
    output logic                       m_valid_out,
    output logic [WIDTH-1:0]           m_data_out,
    input  logic                       m_ready_in,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_out,
    output logic                       full_out,
    output logic                       empty_out,
    output logic                       almost_full_out,
    output logic                       almost_empty_out,
    output logic [$clog2(DEPTH+1)-1:0] peak_occ_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [OW-1:0]    r_occ;

    logic             w_not_empty;
    logic             w_push;
    logic             w_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Everything visible to the write side comes from registered occupancy only,
    // so a pop in the same cycle never opens a full FIFO to a push.
    assign w_not_empty      = (r_occ != '0);
    assign s_ready_out      = (r_occ < OW'(DEPTH));
    assign w_push           = s_valid_in && s_ready_out && !flush_in;
    assign occupancy_out    = r_occ;
    assign full_out         = (r_occ == OW'(DEPTH));
    assign empty_out        = !w_not_empty;
    assign almost_full_out  = (int'(r_occ) >= AFULL_THRESH);
    assign almost_empty_out = (int'(r_occ) <= AEMPTY_THRESH);

    // Storage write port.
    // NOTE: the memory array has no reset; stale words are never observable
    // because reads are qualified by occupancy, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_data_in;
        end
    end

    // Pointer and occupancy bookkeeping; flush discards same-cycle push and pop.
    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // always_ff sees the pre-edge values of the others regardless of evaluation order.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else if (flush_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + OW'(1);
            end else if (w_pop && !w_push) begin
                r_occ <= r_occ - OW'(1);
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Oldest word shown combinationally; data masked to zero while empty.
            // NOTE: every signal written here gets a default first so no latch is inferred.
            always_comb begin
                m_valid_out = w_not_empty;
                m_data_out  = '0;
                w_pop       = w_not_empty && m_ready_in && !flush_in;
                if (w_not_empty) begin
                    m_data_out = r_mem[r_rd_ptr];
                end
            end
        end else begin : g_registered
            logic             r_m_valid;
            logic [WIDTH-1:0] r_m_data;

            // A read request against a non-empty FIFO pops; requests while empty are ignored.
            always_comb begin
                w_pop = m_ready_in && w_not_empty && !flush_in;
            end

            // Popped word lands in the output register for one valid cycle, then holds.
            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    r_m_valid <= 1'b0;
                    r_m_data  <= '0;
                end else begin
                    r_m_valid <= w_pop;
                    if (w_pop) begin
                        r_m_data <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign m_valid_out = r_m_valid;
            assign m_data_out  = r_m_data;
        end
    endgenerate

`ifdef STREAM_FIFO_PEAK_EN
    logic [OW-1:0] r_peak;

    // High-water mark follows registered occupancy one cycle behind; flush clears it.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_peak <= '0;
        end else if (flush_in) begin
            r_peak <= '0;
        end else if (r_occ > r_peak) begin
            r_peak <= r_occ;
        end
    end

    assign peak_occ_out = r_peak;
`else
    assign peak_occ_out = '0;
`endif

endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, storage entries (>=2; non-power-of-2 allowed).
REQ-003 SHALL have parameter AFULL_THRESH, default DEPTH-2, almost-full threshold in entries.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 2, almost-empty threshold in entries.
REQ-005 SHALL have parameter FWFT, default 1: 1 = first-word-fall-through, 0 = registered read (one-cycle read latency).
REQ-006 SHALL use one clock and an asynchronous active-low reset; ports follow.
REQ-007 SHALL have port clk_in, input, 1, rising-edge clock.
REQ-008 SHALL have port rst_n_in, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port flush_in, input, 1, synchronous empty command.
REQ-010 SHALL have port s_valid_in, input, 1, write-side valid.
REQ-011 SHALL have port s_data_in, input, WIDTH, write data.
REQ-012 SHALL have port s_ready_out, output, 1, write-side ready.
REQ-013 SHALL have port m_valid_out, output, 1, read-side valid.
REQ-014 SHALL have port m_data_out, output, WIDTH, read data.
REQ-015 SHALL have port m_ready_in, input, 1: read-side ready when FWFT=1, read request when FWFT=0.
REQ-016 SHALL have port occupancy_out, output, $clog2(DEPTH+1), stored-entry count.
REQ-017 SHALL have ports full_out, empty_out, almost_full_out and almost_empty_out, each output, 1, status flags.
REQ-018 SHALL have port peak_occ_out, output, $clog2(DEPTH+1), high-water mark (see Configuration).

Function
REQ-019 SHALL assert s_ready_out exactly when occupancy < DEPTH, from registered state only; a push SHALL occur when s_valid_in && s_ready_out.
REQ-020 SHALL refuse a push while full, even with a simultaneous pop; there SHALL be no full-pass-through.
REQ-021 When FWFT=1, SHALL drive m_valid_out = (occupancy > 0) and m_data_out = the oldest entry combinationally; a pop SHALL occur when m_valid_out && m_ready_in.
REQ-022 When FWFT=0, a pop SHALL occur when m_ready_in && occupancy > 0, and the popped word SHALL appear on m_data_out with m_valid_out high for exactly the next cycle; m_data_out SHALL hold otherwise.
REQ-023 When FWFT=0, m_ready_in while empty SHALL be ignored, with no pointer change and no m_valid_out pulse.
REQ-024 Push-to-visible latency SHALL be 1 cycle; a word pushed into an empty FIFO SHALL NOT be poppable in its push cycle.
REQ-025 On a simultaneous push and pop, occupancy SHALL be unchanged and both pointers SHALL advance.
REQ-026 Read and write pointers SHALL wrap from DEPTH-1 to 0 for any DEPTH.
REQ-027 Flags SHALL be derived from occupancy: full = DEPTH, empty = 0, almost_full = (occupancy >= AFULL_THRESH), almost_empty = (occupancy <= AEMPTY_THRESH).
REQ-028 Flush SHALL, on the clock edge, zero both pointers and occupancy, discard any same-cycle push or pop, and clear m_valid_out in FWFT=0 mode; memory contents need not be cleared.
REQ-029 Data SHALL emerge in strict push order with no loss or duplication.

Reset
REQ-030 rst_n_in low SHALL immediately zero both pointers, occupancy, m_data_out, m_valid_out and peak_occ_out.
REQ-031 Memory array SHALL NOT be reset.
REQ-032 During and right after reset, outputs SHALL be s_ready_out=1, empty_out=1, almost_empty_out=1, full_out=0, almost_full_out=0.
REQ-033 Reset mid-transfer SHALL drop all stored data; the first push after release SHALL be the first word popped.

Configuration
REQ-034 Macro STREAM_FIFO_PEAK_EN defined: peak_occ_out SHALL register the maximum occupancy since reset or flush, update one cycle after occupancy rises, and clear to 0 on flush.
REQ-035 Macro STREAM_FIFO_PEAK_EN undefined: peak_occ_out SHALL be tied to 0 and no peak logic SHALL be built.

Verification (WIDTH=8, DEPTH=4, AFULL_THRESH=3, AEMPTY_THRESH=1)
REQ-036 FWFT=1: push 0x11,0x22,0x33,0x44 with m_ready_in=0 -> full_out=1, s_ready_out=0, occupancy 4, m_data_out=0x11; 5th push 0x55 is not accepted.
REQ-037 FWFT=1, full: s_valid_in and m_ready_in held 1 for one cycle -> pop 0x11 only, occupancy 3, next m_data_out=0x22.
REQ-038 FWFT=0: push 0xA5, then pulse m_ready_in -> m_valid_out high one cycle later with m_data_out=0xA5; m_ready_in while empty -> no pulse.
REQ-039 Stream 10 words 0x00..0x09 with random valid/ready -> output order 0x00..0x09, pointers wrap twice, occupancy never exceeds 4.
REQ-040 Three words stored, assert flush_in with s_valid_in=1 -> occupancy 0, empty_out=1, pushed word discarded, peak_occ_out 0 (PEAK_EN) or 0 (not defined).
REQ-041 With PEAK_EN, fill to 3, drain to 0, then assert rst_n_in low asynchronously mid-push -> peak reads 3 before reset; all outputs at reset values with no clock edge.
